// File: rtl/ibex_hpm_counter_unit.sv
// ibex_hpm_counter_unit
//   Machine counter/timer unit beside the CSR file: mcycle, minstret,
//   NumCounters mhpmcounterK (K = 3..2+NumCounters) with their mhpmeventK
//   selectors, and mcountinhibit. Each mhpmcounter has a sticky overflow
//   flag (mhpmeventK bit 31) and the unit raises ovf_irq_o while any flag
//   of a non-inhibited counter is set.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   csr_req_i          CSR access request (single-cycle pulse)
//   csr_we_i           1 = write, 0 = read
//   csr_addr_i         12-bit CSR address
//   csr_wdata_i        write data
//   csr_rvalid_o       response valid, one cycle after csr_req_i
//   csr_rdata_o        read data (0 for writes and errors)
//   csr_err_o          address outside this unit's map (qualified by csr_rvalid_o)
//   instr_ret_i        one instruction retired this cycle
//   event_i            per-cycle event strobes
//   ovf_irq_o          OR of overflow flags of non-inhibited counters
//
// Handshake: a request is accepted on every clock edge where csr_req_i is
// high; there is no ready signal and no backpressure. csr_rvalid_o is high
// for exactly the cycle after each accepted request, so back-to-back
// requests produce back-to-back responses in order. Read data is the
// register value at the request edge, before any same-edge update.
module ibex_hpm_counter_unit #(
  parameter int NumCounters  = 8,
  parameter int CounterWidth = 40,
  parameter int NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_req_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic                 csr_rvalid_o,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_err_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  output logic                 ovf_irq_o
);

  localparam int EvtIdxW = (NumEvents > 1) ? $clog2(NumEvents) : 1;
  localparam int EvtExtW = 1 << EvtIdxW;
  localparam int NC      = (NumCounters > 0) ? NumCounters : 1;

  // Writable mcountinhibit bits: cycle (0), instret (2), counters 3..2+N.
  localparam logic [63:0] CntMask = ((64'd1 << NumCounters) - 64'd1) << 3;
  localparam logic [31:0] InhMask = 32'h0000_0005 | CntMask[31:0];

  logic [63:0]             mcycle_q;
  logic [63:0]             minstret_q;
  logic [31:0]             inhibit_q;
  logic [CounterWidth-1:0] cnt_q     [NC];
  logic [EvtIdxW-1:0]      evt_sel_q [NC];
  logic [NC-1:0]           of_q;
  logic                    rvalid_q;
  logic                    err_q;
  logic [31:0]             rdata_q;
  logic                    irq_q;

  logic                    wr_en;
  logic                    hit;
  logic [31:0]             rd_val;
  logic [63:0]             cnt_ext;
  logic                    mcyc_lo_we, mcyc_hi_we, mret_lo_we, mret_hi_we, inh_we;
  logic [NC-1:0]           cnt_lo_we, cnt_hi_we, evt_we;
  logic [NC-1:0]           fire, wrap;
  logic                    irq_d;
  logic [EvtExtW-1:0]      evt_ext;

  assign wr_en   = csr_req_i & csr_we_i;
  // Zero-extend so that any encodable index can be looked up safely.
  assign evt_ext = EvtExtW'(event_i);

  // Replace one 32-bit half of a counter; bits above CounterWidth drop out.
  function automatic logic [CounterWidth-1:0] write_half(
    input logic [CounterWidth-1:0] cur,
    input logic                    hi,
    input logic [31:0]             wd
  );
    logic [63:0] t;
    t = 64'(cur);
    if (hi) t[63:32] = wd;
    else    t[31:0]  = wd;
    return t[CounterWidth-1:0];
  endfunction

  // Address decode, read mux and per-register write strobes.
  always_comb begin
    hit        = 1'b0;
    rd_val     = '0;
    cnt_ext    = '0;
    mcyc_lo_we = 1'b0;
    mcyc_hi_we = 1'b0;
    mret_lo_we = 1'b0;
    mret_hi_we = 1'b0;
    inh_we     = 1'b0;
    cnt_lo_we  = '0;
    cnt_hi_we  = '0;
    evt_we     = '0;
    case (csr_addr_i)
      12'hB00: begin hit = 1'b1; rd_val = mcycle_q[31:0];    mcyc_lo_we = wr_en; end
      12'hB80: begin hit = 1'b1; rd_val = mcycle_q[63:32];   mcyc_hi_we = wr_en; end
      12'hB02: begin hit = 1'b1; rd_val = minstret_q[31:0];  mret_lo_we = wr_en; end
      12'hB82: begin hit = 1'b1; rd_val = minstret_q[63:32]; mret_hi_we = wr_en; end
      12'h320: begin hit = 1'b1; rd_val = inhibit_q;         inh_we     = wr_en; end
      default: ;
    endcase
    for (int k = 0; k < NumCounters; k++) begin
      if (csr_addr_i == 12'hB03 + 12'(k)) begin
        hit          = 1'b1;
        cnt_ext      = 64'(cnt_q[k]);
        rd_val       = cnt_ext[31:0];
        cnt_lo_we[k] = wr_en;
      end
      if (csr_addr_i == 12'hB83 + 12'(k)) begin
        hit          = 1'b1;
        cnt_ext      = 64'(cnt_q[k]);
        rd_val       = cnt_ext[63:32];
        // A 32-bit counter has no high half: accepted without error, ignored.
        cnt_hi_we[k] = wr_en & (CounterWidth > 32);
      end
      if (csr_addr_i == 12'h323 + 12'(k)) begin
        hit       = 1'b1;
        rd_val    = {of_q[k], 31'(evt_sel_q[k])};
        evt_we[k] = wr_en;
      end
    end
  end

  // Per-counter increment enable, wrap detection and interrupt source.
  always_comb begin
    fire  = '0;
    wrap  = '0;
    irq_d = 1'b0;
    for (int k = 0; k < NumCounters; k++) begin
      fire[k] = ~inhibit_q[k+3] & (int'(evt_sel_q[k]) < NumEvents) &
                evt_ext[evt_sel_q[k]];
      // A same-cycle software write replaces the increment, so it cannot wrap.
      wrap[k] = fire[k] & ~cnt_lo_we[k] & ~cnt_hi_we[k] & (&cnt_q[k]);
      irq_d   = irq_d | (of_q[k] & ~inhibit_q[k+3]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inhibit_q  <= '0;
      of_q       <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        cnt_q[k]     <= '0;
        evt_sel_q[k] <= '0;
      end
    end else begin
      rvalid_q <= csr_req_i;
      err_q    <= csr_req_i & ~hit;
      rdata_q  <= (csr_req_i & ~csr_we_i & hit) ? rd_val : 32'd0;
      irq_q    <= irq_d;

      if (inh_we) inhibit_q <= csr_wdata_i & InhMask;

      if (mcyc_lo_we)        mcycle_q[31:0]  <= csr_wdata_i;
      else if (mcyc_hi_we)   mcycle_q[63:32] <= csr_wdata_i;
      else if (!inhibit_q[0]) mcycle_q       <= mcycle_q + 64'd1;

      if (mret_lo_we)        minstret_q[31:0]  <= csr_wdata_i;
      else if (mret_hi_we)   minstret_q[63:32] <= csr_wdata_i;
      else if (!inhibit_q[2] && instr_ret_i) minstret_q <= minstret_q + 64'd1;

      for (int k = 0; k < NumCounters; k++) begin
        if (cnt_lo_we[k])      cnt_q[k] <= write_half(cnt_q[k], 1'b0, csr_wdata_i);
        else if (cnt_hi_we[k]) cnt_q[k] <= write_half(cnt_q[k], 1'b1, csr_wdata_i);
        else if (fire[k])      cnt_q[k] <= cnt_q[k] + CounterWidth'(1);

        // Wrap takes priority over a software clear of the flag.
        if (evt_we[k]) begin
          evt_sel_q[k] <= csr_wdata_i[EvtIdxW-1:0];
          of_q[k]      <= csr_wdata_i[31] | wrap[k];
        end else if (wrap[k]) begin
          of_q[k] <= 1'b1;
        end
      end
    end
  end

  assign csr_rvalid_o = rvalid_q;
  assign csr_err_o    = err_q;
  assign csr_rdata_o  = rdata_q;
  assign ovf_irq_o    = irq_q;

endmodule

// File: tb/tb_ibex_hpm_counter_unit.sv
// Bench for ibex_hpm_counter_unit (default parameters: 8 counters,
// 40-bit counters, 16 events). A reference model of the register map is
// advanced on every clock edge from the applied inputs; a compare process
// checks every DUT output against it on each falling edge. Directed
// sequences add hand-computed literal expectations.
module tb_ibex_hpm_counter_unit;

  localparam int          NCNT  = 8;
  localparam logic [63:0] CMASK = 64'h0000_00FF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        instr_ret = 1'b0;
  logic [15:0] event_i = '0;
  logic        rvalid, err, irq;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  ibex_hpm_counter_unit #(
    .NumCounters (8),
    .CounterWidth(40),
    .NumEvents   (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .csr_req_i   (req),
    .csr_we_i    (we),
    .csr_addr_i  (addr),
    .csr_wdata_i (wdata),
    .csr_rvalid_o(rvalid),
    .csr_rdata_o (rdata),
    .csr_err_o   (err),
    .instr_ret_i (instr_ret),
    .event_i     (event_i),
    .ovf_irq_o   (irq)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mc, m_mi;
  logic [63:0] m_cnt [NCNT];
  logic [3:0]  m_sel [NCNT];
  bit          m_of  [NCNT];
  logic [31:0] m_inh;
  logic        exp_rvalid, exp_err, exp_irq;
  logic [31:0] exp_rdata;
  bit          model_ok = 1'b0;

  // Register map lookup; returns 0 for an unimplemented address.
  function automatic bit m_read(input logic [11:0] a, output logic [31:0] d);
    int k;
    d = '0;
    if (a == 12'h320) begin d = m_inh;         return 1'b1; end
    if (a == 12'hB00) begin d = m_mc[31:0];    return 1'b1; end
    if (a == 12'hB80) begin d = m_mc[63:32];   return 1'b1; end
    if (a == 12'hB02) begin d = m_mi[31:0];    return 1'b1; end
    if (a == 12'hB82) begin d = m_mi[63:32];   return 1'b1; end
    if (a[11:8] == 4'hB) begin
      k = int'(a[6:0]) - 3;
      if (k >= 0 && k < NCNT) begin
        d = a[7] ? m_cnt[k][63:32] : m_cnt[k][31:0];
        return 1'b1;
      end
    end
    k = int'(a) - 'h323;
    if (k >= 0 && k < NCNT) begin
      d = {m_of[k], 27'd0, m_sel[k]};
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [31:0] rd;
    bit          ok;
    logic [63:0] n_mc, n_mi;
    logic [63:0] n_cnt [NCNT];
    logic [3:0]  n_sel [NCNT];
    bit          n_of  [NCNT];
    bit          wrapped [NCNT];
    logic [31:0] n_inh;
    int          k;
    if (!rst_n) begin
      m_mc = '0; m_mi = '0; m_inh = '0;
      for (int i = 0; i < NCNT; i++) begin
        m_cnt[i] = '0; m_sel[i] = '0; m_of[i] = 1'b0;
      end
      exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_irq = 1'b0;
      model_ok = 1'b1;
      return;
    end
    ok         = m_read(addr, rd);
    exp_rvalid = req;
    exp_err    = req && !ok;
    exp_rdata  = (req && !we && ok) ? rd : 32'd0;
    exp_irq    = 1'b0;
    for (int i = 0; i < NCNT; i++)
      if (m_of[i] && !m_inh[i+3]) exp_irq = 1'b1;

    // Counting from the state held before this edge.
    n_inh = m_inh;
    n_mc  = m_inh[0] ? m_mc : m_mc + 1;
    n_mi  = (!m_inh[2] && instr_ret) ? m_mi + 1 : m_mi;
    for (int i = 0; i < NCNT; i++) begin
      n_cnt[i] = m_cnt[i]; n_sel[i] = m_sel[i]; n_of[i] = m_of[i]; wrapped[i] = 1'b0;
      if (!m_inh[i+3] && event_i[m_sel[i]]) begin
        n_cnt[i] = (m_cnt[i] + 1) & CMASK;
        wrapped[i] = (n_cnt[i] == 0);
      end
    end

    // A software write replaces whatever counting would have done.
    if (req && we && ok) begin
      if (addr == 12'h320) n_inh = wdata & 32'h0000_07FD;
      else if (addr == 12'hB00) n_mc = {m_mc[63:32], wdata};
      else if (addr == 12'hB80) n_mc = {wdata, m_mc[31:0]};
      else if (addr == 12'hB02) n_mi = {m_mi[63:32], wdata};
      else if (addr == 12'hB82) n_mi = {wdata, m_mi[31:0]};
      else if (addr[11:8] == 4'hB) begin
        k = int'(addr[6:0]) - 3;
        n_cnt[k]   = addr[7] ? ({wdata, m_cnt[k][31:0]} & CMASK) : {m_cnt[k][63:32], wdata};
        wrapped[k] = 1'b0;
      end else begin
        k = int'(addr) - 'h323;
        n_sel[k] = wdata[3:0];
        n_of[k]  = wdata[31];
      end
    end
    for (int i = 0; i < NCNT; i++) if (wrapped[i]) n_of[i] = 1'b1;

    m_mc = n_mc; m_mi = n_mi; m_inh = n_inh;
    for (int i = 0; i < NCNT; i++) begin
      m_cnt[i] = n_cnt[i]; m_sel[i] = n_sel[i]; m_of[i] = n_of[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("rvalid", 64'(rvalid), 64'(exp_rvalid));
      check("rdata",  64'(rdata),  64'(exp_rdata));
      check("err",    64'(err),    64'(exp_err));
      check("irq",    64'(irq),    64'(exp_irq));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic csr(input bit w, input logic [11:0] a, input logic [31:0] wd,
                     input logic [15:0] evt, output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = wd; event_i = evt;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; event_i = '0;
    rd = rdata; e = err;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    logic        e;
    csr(1'b1, a, wd, 16'h0, rd, e);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    csr(1'b0, a, 32'h0, 16'h0, rd, e);
    check(name, 64'(rd), 64'(exp));
    check({name, "_err"}, 64'(e), 64'd0);
  endtask

  // ---------------- directed sequences ----------------
  localparam logic [11:0] RAND_ADDR [14] = '{
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB05,
    12'hB8A, 12'h323, 12'h32A, 12'h320, 12'hB01, 12'h350, 12'h32B};

  initial begin
    logic [31:0] r1, r2;
    logic        e;

    // Reset, then ten counted cycles before the read is sampled.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    rd_chk("mcycle_idle", 12'hB00, 32'd10);
    rd_chk("minstret_idle", 12'hB02, 32'd0);

    // Event-driven counter and an unimplemented address.
    wr(12'h323, 32'd2);
    event_i = 16'h0004;
    repeat (5) @(posedge clk);
    #1 event_i = '0;
    rd_chk("cnt3_five", 12'hB03, 32'd5);
    csr(1'b0, 12'h350, 32'h0, 16'h0, r1, e);
    check("bad_addr_err", 64'(e), 64'd1);
    check("bad_addr_rdata", 64'(r1), 64'd0);

    // Wrap from all-ones sets the overflow flag and the interrupt.
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    rd_chk("cnt3_hi_width", 12'hB83, 32'h0000_00FF);
    @(posedge clk); #1 event_i = 16'h0004;
    @(posedge clk); #1 event_i = '0;
    rd_chk("cnt3_wrap_lo", 12'hB03, 32'd0);
    rd_chk("cnt3_wrap_hi", 12'hB83, 32'd0);
    rd_chk("evt3_of_set", 12'h323, 32'h8000_0002);
    check("irq_after_wrap", 64'(irq), 64'd1);

    // Flag clear in the same cycle as a wrap loses; a later clear wins.
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0000_00FF);
    csr(1'b1, 12'h323, 32'd2, 16'h0004, r1, e);
    rd_chk("evt3_set_wins", 12'h323, 32'h8000_0002);
    rd_chk("cnt3_after_race", 12'hB03, 32'd0);
    wr(12'h323, 32'd2);
    check("irq_still_high", 64'(irq), 64'd1);
    @(posedge clk); #1;
    check("irq_dropped", 64'(irq), 64'd0);

    // Software-set flag, masked by inhibiting its counter.
    wr(12'h324, 32'hFFFF_FFF3);
    rd_chk("evt4_sw_set", 12'h324, 32'h8000_0003);
    check("irq_sw_set", 64'(irq), 64'd1);
    wr(12'h320, 32'h0000_0010);
    rd_chk("inh_cnt4", 12'h320, 32'h0000_0010);
    check("irq_inhibited", 64'(irq), 64'd0);
    wr(12'h324, 32'h0);
    wr(12'h320, 32'h0);

    // Inhibited cycle/instret counters hold their written values.
    wr(12'h320, 32'h0000_0007);
    rd_chk("inh_bit1_zero", 12'h320, 32'h0000_0005);
    wr(12'hB00, 32'h0000_1234);
    wr(12'hB80, 32'h0);
    wr(12'hB02, 32'h0000_0055);
    wr(12'hB82, 32'h0);
    instr_ret = 1'b1;
    repeat (20) @(posedge clk);
    #1 instr_ret = 1'b0;
    rd_chk("mcycle_frozen", 12'hB00, 32'h0000_1234);
    rd_chk("mcycle_hi_frozen", 12'hB80, 32'h0);
    rd_chk("minstret_frozen", 12'hB02, 32'h0000_0055);

    // Write while counting, then back-to-back reads.
    wr(12'h320, 32'h0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 12'hB00; wdata = 32'd100;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
    r1 = rdata;
    check("b2b_rvalid0", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    req = 1'b0;
    r2 = rdata;
    check("b2b_rvalid1", 64'(rvalid), 64'd1);
    check("mcycle_written", 64'(r1), 64'd100);
    check("mcycle_next", 64'(r2), 64'd101);

    // Mixed traffic, checked against the model every cycle.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      instr_ret = 1'($urandom_range(0, 1));
      event_i   = 16'($urandom_range(0, 16'hFFFF));
      req       = 1'($urandom_range(0, 3) != 0);
      we        = ($urandom_range(0, 3) == 0);
      addr      = RAND_ADDR[$urandom_range(0, 13)];
      wdata     = $urandom;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; instr_ret = 1'b0; event_i = '0;

    // Reset arriving with a request drops its response.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 12'hB00; rst_n = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_drop_rvalid", 64'(rvalid), 64'd0);
    rst_n = 1'b1;
    rd_chk("mcycle_post_rst", 12'hB00, 32'd1);
    rd_chk("cnt3_post_rst", 12'hB03, 32'd0);
    rd_chk("inh_post_rst", 12'h320, 32'd0);
    check("irq_post_rst", 64'(irq), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
